// File: rtl/regfile_alu_sequencer_pkg.sv
// Shared definitions for the register-file ALU sequencer: operation and state
// encodings plus default widths and saturation limits.
package regfile_alu_sequencer_pkg;

  localparam int unsigned AddrW = 4;
  localparam int unsigned NumRegs = 15;
  localparam int unsigned DataW = 8;

  // Saturation limits for the default data width.
  localparam logic [DataW-1:0] SatMax = {1'b0, {(DataW-1){1'b1}}};
  localparam logic [DataW-1:0] SatMin = {1'b1, {(DataW-1){1'b0}}};

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_MAC = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StExec,
    StWrite,
    StDone
  } state_e;

endpackage

// File: rtl/regfile_alu_sequencer_if.sv
// Command and register-file bus seen by the sequencer. The master view belongs
// to the sequencer; the slave view to the command source plus register file.
interface regfile_alu_sequencer_if #(
  parameter int unsigned M = 4,
  parameter int unsigned W = 8
);
  logic         start;
  logic [1:0]   op;
  logic [M-1:0] dst;
  logic [M-1:0] src1;
  logic [M-1:0] src2;
  logic [M-1:0] src3;

  logic         WriteEn;
  logic [M-1:0] WriteReg;
  logic [W-1:0] WriteData;
  logic         ReadEn;
  logic [M-1:0] ReadReg1;
  logic [M-1:0] ReadReg2;
  logic [M-1:0] ReadReg3;
  logic [W-1:0] ReadData1;
  logic [W-1:0] ReadData2;
  logic [W-1:0] ReadData3;

  logic         busy;
  logic         done;
  logic         ovf;
  logic         err;

  modport master (
    input  start, op, dst, src1, src2, src3, ReadData1, ReadData2, ReadData3,
    output WriteEn, WriteReg, WriteData, ReadEn, ReadReg1, ReadReg2, ReadReg3,
    output busy, done, ovf, err
  );

  modport slave (
    output start, op, dst, src1, src2, src3, ReadData1, ReadData2, ReadData3,
    input  WriteEn, WriteReg, WriteData, ReadEn, ReadReg1, ReadReg2, ReadReg3,
    input  busy, done, ovf, err
  );
endinterface

// File: rtl/regfile_alu_sequencer_sat_alu.sv
// Combinational signed ALU with saturation to the W-bit two's complement range.
module sat_alu
  import regfile_alu_sequencer_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  op_e          op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] result,
  output logic         ovf
);

  // 2W+1 bits holds every ADD/SUB/MUL/MAC result without wrapping.
  localparam logic signed [2*W:0] WideMax = {{(W+2){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W:0] WideMin = {{(W+2){1'b1}}, {(W-1){1'b0}}};
  localparam logic [W-1:0] NarrowMax = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] NarrowMin = {1'b1, {(W-1){1'b0}}};

  logic signed [2*W:0] ae, be, ce, full;

  // Sign-extend operands, evaluate the op at full precision, then clamp.
  always_comb begin
    ae     = {{(W+1){a[W-1]}}, a};
    be     = {{(W+1){b[W-1]}}, b};
    ce     = {{(W+1){c[W-1]}}, c};
    full   = '0;
    result = '0;
    ovf    = 1'b0;
    unique case (op)
      OP_ADD: full = ae + be;
      OP_SUB: full = ae - be;
      OP_MUL: full = ae * be;
      OP_MAC: full = ae * be + ce;
    endcase
    if (full > WideMax) begin
      result = NarrowMax;
      ovf    = 1'b1;
    end else if (full < WideMin) begin
      result = NarrowMin;
      ovf    = 1'b1;
    end else begin
      result = full[W-1:0];
    end
  end

endmodule

// File: rtl/regfile_alu_sequencer.sv
// Sequencer that reads up to three registers, runs a saturating ALU op and
// writes the result back, one command at a time.
module regfile_alu_sequencer
  import regfile_alu_sequencer_pkg::*;
#(
  parameter int unsigned M = AddrW,
  parameter int unsigned N = NumRegs,
  parameter int unsigned W = DataW
) (
  input logic                    clk,
  input logic                    rst_n,  // active-high despite the name
  regfile_alu_sequencer_if.master bus
);

  state_e       state;
  op_e          op_q;
  logic [W-1:0] alu_result;
  logic         alu_ovf;
  logic         cmd_bad;

  function automatic logic addr_bad(input logic [M-1:0] addr);
    return 32'(addr) >= N;
  endfunction

  sat_alu #(
    .W(W)
  ) u_alu (
    .op    (op_q),
    .a     (bus.ReadData1),
    .b     (bus.ReadData2),
    .c     (bus.ReadData3),
    .result(alu_result),
    .ovf   (alu_ovf)
  );

  // Reject commands whose used addresses fall outside the implemented registers.
  always_comb begin
    cmd_bad = addr_bad(bus.dst) || addr_bad(bus.src1) || addr_bad(bus.src2) ||
              ((op_e'(bus.op) == OP_MAC) && addr_bad(bus.src3));
  end

  // Command FSM; every output is a register updated for the state being entered.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state         <= StIdle;
      op_q          <= OP_ADD;
      bus.WriteEn   <= 1'b0;
      bus.WriteReg  <= '0;
      bus.WriteData <= '0;
      bus.ReadEn    <= 1'b0;
      bus.ReadReg1  <= '0;
      bus.ReadReg2  <= '0;
      bus.ReadReg3  <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.ovf       <= 1'b0;
      bus.err       <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (bus.start) begin
            op_q         <= op_e'(bus.op);
            bus.WriteReg <= bus.dst;
            bus.ReadReg1 <= bus.src1;
            bus.ReadReg2 <= bus.src2;
            bus.ReadReg3 <= bus.src3;
            bus.ovf      <= 1'b0;
            bus.busy     <= 1'b1;
            if (cmd_bad) begin
              bus.err  <= 1'b1;
              bus.done <= 1'b1;
              state    <= StDone;
            end else begin
              bus.err    <= 1'b0;
              bus.ReadEn <= 1'b1;
              state      <= StRead;
            end
          end
        end
        StRead: begin
          bus.ReadEn <= 1'b0;
          state      <= StExec;
        end
        StExec: begin
          bus.WriteData <= alu_result;
          bus.ovf       <= alu_ovf;
          bus.WriteEn   <= 1'b1;
          state         <= StWrite;
        end
        StWrite: begin
          bus.WriteEn <= 1'b0;
          bus.done    <= 1'b1;
          state       <= StDone;
        end
        StDone: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_alu_sequencer.sv
// Directed bench: behavioural register file plus hand-computed expectations.
module tb_regfile_alu_sequencer;
  import regfile_alu_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  regfile_alu_sequencer_if #(.M(4), .W(8)) bus ();

  regfile_alu_sequencer #(
    .M(4),
    .N(15),
    .W(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural register file: write has priority, read data one cycle later.
  logic [7:0] rf [0:15];
  logic       pl_en = 1'b0;
  logic [3:0] pl_addr = '0;
  logic [7:0] pl_data = '0;

  always @(posedge clk) begin
    if (pl_en) rf[pl_addr] <= pl_data;
    if (bus.WriteEn) rf[bus.WriteReg] <= bus.WriteData;
    else if (bus.ReadEn) begin
      bus.ReadData1 <= rf[bus.ReadReg1];
      bus.ReadData2 <= rf[bus.ReadReg2];
      bus.ReadData3 <= rf[bus.ReadReg3];
    end
  end

  int   rd_cnt = 0;
  int   wr_cnt = 0;
  logic both_seen = 1'b0;

  always @(negedge clk) begin
    if (bus.ReadEn) rd_cnt++;
    if (bus.WriteEn) wr_cnt++;
    if (bus.ReadEn && bus.WriteEn) both_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [3:0] a, input logic [7:0] d);
    pl_en = 1'b1;
    pl_addr = a;
    pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  // Leaves the bench #1 after the accepting edge.
  task automatic drive_cmd(input logic [1:0] op, input logic [3:0] dst, input logic [3:0] s1,
                           input logic [3:0] s2, input logic [3:0] s3);
    bus.op = op;
    bus.dst = dst;
    bus.src1 = s1;
    bus.src2 = s2;
    bus.src3 = s3;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [3:0] dst,
                        input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] s3,
                        input logic [7:0] exp_data, input logic exp_ovf);
    int rd0;
    int wr0;
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    drive_cmd(op, dst, s1, s2, s3);
    check({tag, " read ReadEn"}, 32'(bus.ReadEn), 32'd1);
    check({tag, " read WriteEn"}, 32'(bus.WriteEn), 32'd0);
    check({tag, " read busy"}, 32'(bus.busy), 32'd1);
    check({tag, " ReadReg1"}, 32'(bus.ReadReg1), 32'(s1));
    check({tag, " ReadReg2"}, 32'(bus.ReadReg2), 32'(s2));
    tick();
    check({tag, " exec ReadEn"}, 32'(bus.ReadEn), 32'd0);
    check({tag, " exec WriteEn"}, 32'(bus.WriteEn), 32'd0);
    tick();
    check({tag, " write WriteEn"}, 32'(bus.WriteEn), 32'd1);
    check({tag, " write ReadEn"}, 32'(bus.ReadEn), 32'd0);
    check({tag, " WriteReg"}, 32'(bus.WriteReg), 32'(dst));
    check({tag, " WriteData"}, 32'(bus.WriteData), 32'(exp_data));
    tick();
    check({tag, " done"}, 32'(bus.done), 32'd1);
    check({tag, " ovf"}, 32'(bus.ovf), 32'(exp_ovf));
    check({tag, " err"}, 32'(bus.err), 32'd0);
    check({tag, " done WriteEn"}, 32'(bus.WriteEn), 32'd0);
    tick();
    check({tag, " idle done"}, 32'(bus.done), 32'd0);
    check({tag, " idle busy"}, 32'(bus.busy), 32'd0);
    check({tag, " read count"}, 32'(rd_cnt - rd0), 32'd1);
    check({tag, " write count"}, 32'(wr_cnt - wr0), 32'd1);
    check({tag, " rf dst"}, 32'(rf[dst]), 32'(exp_data));
  endtask

  initial begin
    int rd0;
    int wr0;
    bus.start = 1'b0;
    bus.op = '0;
    bus.dst = '0;
    bus.src1 = '0;
    bus.src2 = '0;
    bus.src3 = '0;
    bus.ReadData1 = '0;
    bus.ReadData2 = '0;
    bus.ReadData3 = '0;

    // Power-on reset
    tick();
    tick();
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset WriteData", 32'(bus.WriteData), 32'd0);
    rst_n = 1'b0;
    repeat (10) tick();
    check("post-reset reads", 32'(rd_cnt), 32'd0);
    check("post-reset writes", 32'(wr_cnt), 32'd0);

    // ADD 5 + -3 = 2
    preload(4'd1, 8'd5);
    preload(4'd2, 8'hFD);
    run_op("add", OP_ADD, 4'd4, 4'd1, 4'd2, 4'd0, 8'h02, 1'b0);

    // SUB -128 - 1 clamps low; ADD 127 + 1 clamps high
    preload(4'd1, 8'h80);
    preload(4'd2, 8'h01);
    run_op("sub_sat", OP_SUB, 4'd4, 4'd1, 4'd2, 4'd0, 8'h80, 1'b1);
    preload(4'd1, 8'h7F);
    run_op("add_sat", OP_ADD, 4'd4, 4'd1, 4'd2, 4'd0, 8'h7F, 1'b1);

    // MUL 100 * 2 = 200 -> 127; 100 * -2 = -200 -> -128
    preload(4'd1, 8'd100);
    preload(4'd2, 8'd2);
    run_op("mul_pos", OP_MUL, 4'd5, 4'd1, 4'd2, 4'd0, 8'h7F, 1'b1);
    preload(4'd2, 8'hFE);
    run_op("mul_neg", OP_MUL, 4'd5, 4'd1, 4'd2, 4'd0, 8'h80, 1'b1);
    tick();
    check("ovf held", 32'(bus.ovf), 32'd1);

    // Reset while idle clears held status and registered outputs at once
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    rst_n = 1'b1;
    #1;
    check("idle reset ovf", 32'(bus.ovf), 32'd0);
    check("idle reset WriteData", 32'(bus.WriteData), 32'd0);
    check("idle reset WriteReg", 32'(bus.WriteReg), 32'd0);
    check("idle reset ReadReg1", 32'(bus.ReadReg1), 32'd0);
    tick();
    rst_n = 1'b0;
    repeat (10) tick();
    check("idle reset reads", 32'(rd_cnt - rd0), 32'd0);
    check("idle reset writes", 32'(wr_cnt - wr0), 32'd0);

    // MAC: -20*7+10 = -130; -140 + -106 = -246; 3*4 + -2 = 10
    preload(4'd1, 8'hEC);
    preload(4'd2, 8'd7);
    preload(4'd3, 8'd10);
    run_op("mac_a", OP_MAC, 4'd6, 4'd1, 4'd2, 4'd3, 8'h80, 1'b1);
    preload(4'd3, 8'h96);
    run_op("mac_b", OP_MAC, 4'd6, 4'd1, 4'd2, 4'd3, 8'h80, 1'b1);
    preload(4'd1, 8'd3);
    preload(4'd2, 8'd4);
    preload(4'd3, 8'hFE);
    run_op("mac_c", OP_MAC, 4'd6, 4'd1, 4'd2, 4'd3, 8'h0A, 1'b0);

    // Out-of-range src2: straight to DONE with err, no bus activity
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    drive_cmd(OP_ADD, 4'd4, 4'd1, 4'd15, 4'd0);
    check("bad done", 32'(bus.done), 32'd1);
    check("bad err", 32'(bus.err), 32'd1);
    check("bad ReadEn", 32'(bus.ReadEn), 32'd0);
    tick();
    check("bad idle busy", 32'(bus.busy), 32'd0);
    check("bad err held", 32'(bus.err), 32'd1);
    tick();
    check("bad reads", 32'(rd_cnt - rd0), 32'd0);
    check("bad writes", 32'(wr_cnt - wr0), 32'd0);

    // src3 out of range is ignored for a non-MAC op
    preload(4'd1, 8'd5);
    preload(4'd2, 8'hFD);
    run_op("src3_unused", OP_ADD, 4'd4, 4'd1, 4'd2, 4'd15, 8'h02, 1'b0);

    // start during EXEC is ignored
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    drive_cmd(OP_ADD, 4'd8, 4'd1, 4'd2, 4'd0);
    tick();
    bus.start = 1'b1;
    bus.op = OP_MUL;
    bus.dst = 4'd9;
    tick();
    bus.start = 1'b0;
    check("busy WriteReg", 32'(bus.WriteReg), 32'd8);
    check("busy WriteData", 32'(bus.WriteData), 32'h02);
    repeat (4) tick();
    check("busy idle", 32'(bus.busy), 32'd0);
    check("busy reads", 32'(rd_cnt - rd0), 32'd1);
    check("busy writes", 32'(wr_cnt - wr0), 32'd1);

    // Reset during READ: no write, destination untouched
    preload(4'd7, 8'h33);
    wr0 = wr_cnt;
    drive_cmd(OP_ADD, 4'd7, 4'd1, 4'd2, 4'd0);
    rst_n = 1'b1;
    #1;
    check("rst read ReadEn", 32'(bus.ReadEn), 32'd0);
    check("rst read busy", 32'(bus.busy), 32'd0);
    tick();
    rst_n = 1'b0;
    repeat (5) tick();
    check("rst read writes", 32'(wr_cnt - wr0), 32'd0);
    check("rst read rf7", 32'(rf[7]), 32'h33);
    check("rst read idle", 32'(bus.busy), 32'd0);

    check("read/write overlap", 32'(both_seen), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_alu_sequencer.md
Name: regfile_alu_sequencer

Overview:
- Initiator-side partner of the 15x8 three-read-port register file.
- Accepts one operation command at a time and reads up to three source registers through the register file read port.
- Computes a signed saturating result, writes it back to a destination register, and pulses done.
- Sits between the top-level command source and the register file; it is the only master of that file's read/write port.

Parameters:
- M, 4, register address width
- N, 15, number of implemented registers (valid addresses 0..N-1)
- W, 8, data width (two's complement signed)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-high (despite the name); same net that initialises the register file
- start  in  1  command strobe, sampled in IDLE only
- op  in  2  operation: 0 ADD (a+b), 1 SUB (a-b), 2 MUL (a*b), 3 MAC (a*b+c)
- dst  in  M  destination register address
- src1, src2, src3  in  M each  operand addresses a, b, c (src3 used by MAC only)
- WriteEn  out  1  register file write enable
- WriteReg  out  M  register file write address
- WriteData  out  W  register file write data (signed)
- ReadEn  out  1  register file read enable
- ReadReg1, ReadReg2, ReadReg3  out  M each  register file read addresses
- ReadData1, ReadData2, ReadData3  in  W each  register file read data (signed), valid the cycle after ReadEn
- busy  out  1  high from command accept until done
- done  out  1  one-cycle completion pulse
- ovf  out  1  result saturated; valid with done, held until next accept
- err  out  1  address out of range; valid with done, held until next accept

Behaviour:
- Reset (async, rst_n=1): state IDLE; all outputs 0; latched command registers 0.
- FSM states: IDLE, READ, EXEC, WRITE, DONE.
- IDLE: on a clk edge with start=1, latch op/dst/src1..3, clear ovf/err, go to READ. If any used address is >= N (src3 ignored unless MAC), set err=1 and go directly to DONE; no ReadEn, no WriteEn.
- READ (1 cycle): ReadEn=1, ReadReg1..3 = latched src1..3, WriteEn=0. Go to EXEC.
- EXEC (1 cycle): ReadEn=0. ReadData1..3 are valid this cycle. Compute and register result and ovf at the closing edge. Go to WRITE.
- WRITE (1 cycle): WriteEn=1, WriteReg=dst, WriteData=result, ReadEn=0. Go to DONE.
- DONE (1 cycle): done=1. Go to IDLE.
- Latency: start edge T -> READ T+1, EXEC T+2, WRITE T+3, done high in cycle T+4. Next start is accepted at the edge ending DONE+1 (IDLE).
- ReadEn and WriteEn are never high in the same cycle; the register file gives WriteEn priority and must never see both.
- ReadReg*, WriteReg and WriteData hold the latched or registered values in every state and are 0 only after reset.
- busy=1 in READ, EXEC, WRITE and DONE.
- start outside IDLE is ignored; a command is never queued.
- Arithmetic: operands sign-extended.
  - ADD/SUB computed at W+1 bits.
  - MUL product 2W bits.
  - MAC 2W+1 bits.
  - Result saturates to [-2^(W-1), 2^(W-1)-1] = [-128, 127]; ovf=1 iff clamped.
- Reset mid-operation: immediate return to IDLE with all outputs 0. A command reset before WRITE performs no write. Reset during WRITE drops WriteEn asynchronously; whether that write lands is undefined and is not relied upon.

Decomposition:
- Shared package: op encodings (OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_MAC=3), state encodings, saturation min/max constants derived from W.
- One sub-module: sat_alu, purely combinational. Inputs op, a, b, c; outputs result[W-1:0] and ovf. The sequencer registers its outputs in EXEC.

Test Plan:
- Reset: assert rst_n mid-idle -> all outputs 0, busy=0; release, no spurious ReadEn/WriteEn for 10 cycles.
- ADD: R1=5, R2=-3 (0xFD), start op=0 dst=4 src1=1 src2=2 at T -> ReadEn only in T+1; WriteEn in T+3 with WriteReg=4, WriteData=0x02; done pulse in T+4 with ovf=0, err=0.
- MUL saturation: R1=100, R2=2, op=2 dst=5 -> WriteData=0x7F (127), ovf=1. Repeat with R2=-2 -> 0x80, ovf=1.
- MAC: R1=-20, R2=7, R3=10, op=3 dst=6 -> -130 clamps to 0x80, ovf=1. Repeat with R3=150 (0x96 = -106): -140-106 = -246 -> 0x80, ovf=1. Repeat with R1=3, R2=4, R3=-2 -> 0x0A, ovf=0.
- Invalid address: src2=15 with op=0 -> no ReadEn or WriteEn ever; done at T+1 with err=1. Same with src3=15 and op=0 -> accepted normally (src3 unused).
- Busy/reset: pulse start again in EXEC -> ignored, exactly one WriteEn. Assert rst_n during READ -> IDLE next, no WriteEn, destination register unchanged.
